// File: rtl/fpnew_hub_addmul_sched.sv
// Issues ADD/MUL requests to an adder and a multiplier and returns their results in
// request order, tracked by an order FIFO; unsupported ops complete at once with NV set.
package fpnew_pkg;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module fpnew_hub_addmul_sched #(
  parameter int unsigned Width    = 32,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned Depth    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2*Width-1:0]    operands_i,
  input  fpnew_pkg::operation_e op_i,
  input  logic [TagWidth-1:0]   tag_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic                  unit_flush_o,
  output logic [2*Width-1:0]    add_operands_o,
  output logic [2*Width-1:0]    mul_operands_o,
  output logic                  add_valid_o,
  input  logic                  add_ready_i,
  output logic                  mul_valid_o,
  input  logic                  mul_ready_i,
  input  logic [Width-1:0]      add_result_i,
  input  logic [Width-1:0]      mul_result_i,
  input  logic [4:0]            add_status_i,
  input  logic [4:0]            mul_status_i,
  input  logic                  add_out_valid_i,
  output logic                  add_out_ready_o,
  input  logic                  mul_out_valid_i,
  output logic                  mul_out_ready_o,
  output logic [Width-1:0]      result_o,
  output logic [4:0]            status_o,
  output logic [TagWidth-1:0]   tag_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {KIND_ADD, KIND_MUL, KIND_ILL} kind_e;

  typedef struct packed {
    kind_e               kind;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t          fifo_reg [Depth];
  logic [PtrW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CntW-1:0] count_reg, count_next;

  kind_e  in_kind;
  entry_t head;
  logic   full, empty, accept_ok, unit_ready, push, pop;

  assign in_kind = (op_i == fpnew_pkg::ADD) ? KIND_ADD :
                   (op_i == fpnew_pkg::MUL) ? KIND_MUL : KIND_ILL;

  assign full  = (count_reg == CntW'(Depth));
  assign empty = (count_reg == '0);
  assign head  = fifo_reg[rd_ptr_reg];

  assign add_operands_o = operands_i;
  assign mul_operands_o = operands_i;
  assign unit_flush_o   = flush_i;
  assign busy_o         = !empty;

  always_comb begin
    unit_ready = 1'b1;
    case (in_kind)
      KIND_ADD: unit_ready = add_ready_i;
      KIND_MUL: unit_ready = mul_ready_i;
      default:  unit_ready = 1'b1;
    endcase
  end

  // Acceptance never looks at this cycle's pop: a full FIFO stays closed until the next edge.
  assign accept_ok   = rst_ni && !full && !flush_i;
  assign in_ready_o  = accept_ok && unit_ready;
  assign add_valid_o = accept_ok && in_valid_i && (in_kind == KIND_ADD);
  assign mul_valid_o = accept_ok && in_valid_i && (in_kind == KIND_MUL);
  assign push        = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_o     = 1'b0;
    add_out_ready_o = 1'b0;
    mul_out_ready_o = 1'b0;
    result_o        = '0;
    status_o        = '0;
    tag_o           = '0;
    if (!empty) begin
      tag_o = head.tag;
      case (head.kind)
        KIND_ADD: begin
          out_valid_o     = add_out_valid_i;
          add_out_ready_o = out_ready_i;
          result_o        = add_result_i;
          status_o        = add_status_i;
        end
        KIND_MUL: begin
          out_valid_o     = mul_out_valid_i;
          mul_out_ready_o = out_ready_i;
          result_o        = mul_result_i;
          status_o        = mul_status_i;
        end
        default: begin
          out_valid_o = 1'b1;
          status_o    = 5'b10000; // invalid-operation flag only
        end
      endcase
      if (!rst_ni) begin
        out_valid_o     = 1'b0;
        add_out_ready_o = 1'b0;
        mul_out_ready_o = 1'b0;
      end
    end
  end

  assign pop        = out_valid_o && out_ready_i;
  assign count_next = count_reg + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_reg[wr_ptr_reg] <= '{kind: in_kind, tag: tag_i};
  end

endmodule
